// File: rtl/acc_session_arbiter_if.sv
// Requester, accumulator and response signals of acc_session_arbiter.
// master = requesters/accumulator side, slave = arbiter side.
interface acc_session_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 128
);
  logic [NREQ-1:0]   req_vld;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ-1:0]   req_rdy;
  logic              acc_pass_r;
  logic              acc_clear_r;
  logic [W-1:0]      acc_x_r;
  logic [W-1:0]      acc_y;
  logic              acc_y_vld;
  logic [NREQ-1:0]   rsp_vld;
  logic [W-1:0]      rsp_y;
  logic              busy_r;
  logic              err_r;

  modport master (
    output req_vld, req_last, req_x, acc_y, acc_y_vld,
    input  req_rdy, acc_pass_r, acc_clear_r, acc_x_r, rsp_vld, rsp_y, busy_r, err_r
  );

  modport slave (
    input  req_vld, req_last, req_x, acc_y, acc_y_vld,
    output req_rdy, acc_pass_r, acc_clear_r, acc_x_r, rsp_vld, rsp_y, busy_r, err_r
  );
endinterface

// File: rtl/acc_session_arbiter.sv
// Round-robin session arbiter sharing one wide accumulator among NREQ requesters.
// Optional ACC_ARB_PARTIAL_EN: return the running sum after every beat, not only the last.
module acc_session_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 128,
  parameter int unsigned ACC_LAT = 4
) (
  input logic                  clk,
  input logic                  rst,
  acc_session_arbiter_if.slave bus
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, SESS} state_t;

  state_t          state, state_nx;
  logic [OW-1:0]   owner_r, owner_nx, rr_r, rr_nx, pick, owner_inc;
  logic            first_r, first_nx;
  logic            found, hs, beat_last;
  logic [W-1:0]    beat_x;
  logic [OW-1:0]   pass_owner_r;
  logic            pass_last_r;
  logic [ACC_LAT-1:0] tag_vld, tag_last;
  logic [OW-1:0]   tag_owner [ACC_LAT];
  int unsigned     idx;

  // Round-robin scan starting at rr_r; first valid requester wins.
  always_comb begin
    found = 1'b0;
    pick  = rr_r;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_r) + k) % NREQ;
      if (!found && bus.req_vld[OW'(idx)]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  assign owner_inc = (owner_r == OW'(NREQ - 1)) ? '0 : owner_r + 1'b1;
  assign beat_x    = bus.req_x[32'(owner_r) * W +: W];
  assign beat_last = bus.req_last[owner_r];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner_r <= '0;
      rr_r    <= '0;
      first_r <= 1'b0;
    end else begin
      state   <= state_nx;
      owner_r <= owner_nx;
      rr_r    <= rr_nx;
      first_r <= first_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner_r;
    rr_nx    = rr_r;
    first_nx = first_r;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = SESS;
          owner_nx = pick;
          first_nx = 1'b1;
        end
      end
      SESS: begin
        if (hs) begin
          first_nx = 1'b0;
          if (beat_last) begin
            state_nx = IDLE;
            rr_nx    = owner_inc;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // IDLE never grants, so every session starts with one bubble cycle.
  always_comb begin
    bus.req_rdy = '0;
    hs          = 1'b0;
    if (state == SESS) begin
      bus.req_rdy[owner_r] = bus.req_vld[owner_r];
      hs                   = bus.req_vld[owner_r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.acc_pass_r  <= 1'b0;
      bus.acc_clear_r <= 1'b0;
      bus.acc_x_r     <= '0;
      pass_owner_r    <= '0;
      pass_last_r     <= 1'b0;
    end else begin
      bus.acc_pass_r  <= hs;
      bus.acc_clear_r <= hs & first_r;
      if (hs) begin
        bus.acc_x_r  <= beat_x;
        pass_owner_r <= owner_r;
        pass_last_r  <= beat_last;
      end
    end
  end

  // Tag pipe tracks each issued beat through the accumulator latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_last <= '0;
      for (int unsigned k = 0; k < ACC_LAT; k++) tag_owner[k] <= '0;
    end else begin
      tag_vld[0]   <= bus.acc_pass_r;
      tag_last[0]  <= pass_last_r;
      tag_owner[0] <= pass_owner_r;
      for (int unsigned k = 1; k < ACC_LAT; k++) begin
        tag_vld[k]   <= tag_vld[k-1];
        tag_last[k]  <= tag_last[k-1];
        tag_owner[k] <= tag_owner[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.err_r <= 1'b0;
    else     bus.err_r <= bus.err_r | (bus.acc_y_vld != tag_vld[ACC_LAT-1]);
  end

  always_comb begin
    bus.rsp_vld = '0;
`ifdef ACC_ARB_PARTIAL_EN
    if (bus.acc_y_vld && tag_vld[ACC_LAT-1])
      bus.rsp_vld[tag_owner[ACC_LAT-1]] = 1'b1;
`else
    if (bus.acc_y_vld && tag_vld[ACC_LAT-1] && tag_last[ACC_LAT-1])
      bus.rsp_vld[tag_owner[ACC_LAT-1]] = 1'b1;
`endif
  end

`ifdef ACC_ARB_PARTIAL_EN
  logic unused_tag_last;
  assign unused_tag_last = tag_last[ACC_LAT-1];
`endif

  assign bus.rsp_y  = bus.acc_y;
  assign bus.busy_r = (state == SESS) | bus.acc_pass_r | (|tag_vld);
endmodule

// File: tb/tb_acc_session_arbiter.sv
// Scoreboard bench for acc_session_arbiter with a behavioural accumulator model.
module tb_acc_session_arbiter;
  localparam int NREQ    = 4;
  localparam int W       = 128;
  localparam int ACC_LAT = 4;
`ifdef ACC_ARB_PARTIAL_EN
  localparam bit PARTIAL = 1'b1;
`else
  localparam bit PARTIAL = 1'b0;
`endif

  typedef struct packed { logic [W-1:0] x; logic last; logic [7:0] gap; } beat_t;
  typedef struct packed { logic [NREQ-1:0] oh; logic [W-1:0] y; logic [31:0] cyc; } rsp_t;
  typedef struct packed { logic [W-1:0] x; logic clr; logic [31:0] cyc; } pass_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acc_session_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  acc_session_arbiter #(.NREQ(NREQ), .W(W), .ACC_LAT(ACC_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator model: clear/pass in, sum out ACC_LAT cycles later.
  logic [W-1:0]       am_sum, am_next;
  logic [W-1:0]       am_y [ACC_LAT];
  logic [ACC_LAT-1:0] am_v;
  logic               force_yvld = 1'b0;
  assign am_next = bus.acc_clear_r ? bus.acc_x_r : am_sum + bus.acc_x_r;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      am_sum <= '0;
      am_v   <= '0;
      for (int k = 0; k < ACC_LAT; k++) am_y[k] <= '0;
    end else begin
      if (bus.acc_pass_r) am_sum <= am_next;
      am_v[0] <= bus.acc_pass_r;
      am_y[0] <= am_next;
      for (int k = 1; k < ACC_LAT; k++) begin
        am_v[k] <= am_v[k-1];
        am_y[k] <= am_y[k-1];
      end
    end
  end
  assign bus.acc_y     = am_y[ACC_LAT-1];
  assign bus.acc_y_vld = am_v[ACC_LAT-1] | force_yvld;

  beat_t       bq [NREQ][$];
  rsp_t        rsp_q[$];
  pass_t       pass_q[$];
  logic [W-1:0] m_sum [NREQ];
  logic        m_first [NREQ];
  int unsigned hs_first [NREQ];
  int unsigned hs_last [NREQ];
  int unsigned n_cmp = 0, n_err = 0, n_rsp = 0;

  function automatic beat_t mk(input logic [W-1:0] x, input logic last, input logic [7:0] gap);
    beat_t b;
    b.x = x; b.last = last; b.gap = gap;
    return b;
  endfunction

  task automatic drive();
    logic [NREQ-1:0]   v, l;
    logic [NREQ*W-1:0] xs;
    beat_t h;
    v = '0; l = '0; xs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bq[i].size() > 0) begin
        h = bq[i].pop_front();
        if (h.gap != 0) h.gap = h.gap - 8'd1;
        else begin
          v[i] = 1'b1;
          l[i] = h.last;
          xs[i*W +: W] = h.x;
        end
        bq[i].push_front(h);
      end
    end
    bus.req_vld  = v;
    bus.req_last = l;
    bus.req_x    = xs;
  endtask

  // One clock: drive, check passes/responses on the falling edge, log handshakes.
  task automatic step();
    logic [NREQ-1:0] acc;
    beat_t h;
    rsp_t  r;
    pass_t p;
    drive();
    @(negedge clk);
    n_cmp++;
    if (((bus.req_rdy & ~bus.req_vld) !== '0) || ($countones(bus.req_rdy) > 1)) begin
      n_err++;
      $display("FAIL rdy_legal: rdy=%b vld=%b", bus.req_rdy, bus.req_vld);
    end
    if (bus.acc_pass_r === 1'b1) begin
      n_cmp++;
      if (pass_q.size() == 0) begin
        n_err++;
        $display("FAIL pass_unexpected: x=%0h clr=%b cyc=%0d, none expected", bus.acc_x_r, bus.acc_clear_r, cyc);
      end else begin
        p = pass_q.pop_front();
        if ({bus.acc_x_r, bus.acc_clear_r, cyc} !== {p.x, p.clr, p.cyc}) begin
          n_err++;
          $display("FAIL pass_beat: got x=%0h clr=%b cyc=%0d, want x=%0h clr=%b cyc=%0d",
                   bus.acc_x_r, bus.acc_clear_r, cyc, p.x, p.clr, p.cyc);
        end
      end
    end else if (pass_q.size() > 0 && pass_q[0].cyc <= cyc) begin
      n_cmp++; n_err++;
      p = pass_q.pop_front();
      $display("FAIL pass_missing: got pass=0 at cyc %0d, want x=%0h", cyc, p.x);
    end
    if (bus.rsp_vld !== '0) begin
      n_cmp++; n_rsp++;
      if (rsp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: vld=%b y=%0h cyc=%0d, none expected", bus.rsp_vld, bus.rsp_y, cyc);
      end else begin
        r = rsp_q.pop_front();
        if ({bus.rsp_vld, bus.rsp_y, cyc} !== {r.oh, r.y, r.cyc}) begin
          n_err++;
          $display("FAIL rsp: got vld=%b y=%0h cyc=%0d, want vld=%b y=%0h cyc=%0d",
                   bus.rsp_vld, bus.rsp_y, cyc, r.oh, r.y, r.cyc);
        end
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
      n_cmp++; n_err++;
      r = rsp_q.pop_front();
      $display("FAIL rsp_missing: got vld=0 at cyc %0d, want vld=%b y=%0h", cyc, r.oh, r.y);
    end
    acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_vld[i] && bus.req_rdy[i] && bq[i].size() > 0) begin
        h = bq[i][0];
        if (m_first[i]) begin
          m_sum[i]    = h.x;
          hs_first[i] = cyc;
        end else begin
          m_sum[i] = m_sum[i] + h.x;
        end
        p.x = h.x; p.clr = m_first[i]; p.cyc = cyc + 1;
        pass_q.push_back(p);
        if (h.last || PARTIAL) begin
          r.oh = '0; r.oh[i] = 1'b1; r.y = m_sum[i]; r.cyc = cyc + 1 + ACC_LAT;
          rsp_q.push_back(r);
        end
        if (h.last) hs_last[i] = cyc;
        m_first[i] = h.last;
        acc[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) void'(bq[i].pop_front());
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) if (bq[i].size() > 0) return 1'b1;
    return (rsp_q.size() > 0) || (pass_q.size() > 0);
  endfunction

  task automatic run(input int unsigned max_cyc);
    int unsigned n = 0;
    while ((pending() || bus.busy_r) && n < max_cyc) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= max_cyc) begin
      n_err++;
      $display("FAIL run_timeout: got still busy after %0d cycles, want drained", n);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_vld = '0; bus.req_last = '0; bus.req_x = '0;
    force_yvld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bq[i].delete();
      m_first[i] = 1'b1;
      m_sum[i]   = '0;
    end
    rsp_q.delete();
    pass_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    bus.req_vld = '0; bus.req_last = '0; bus.req_x = '0;
    @(negedge clk);
    n_cmp++;
    if ({bus.req_rdy, bus.acc_pass_r, bus.acc_clear_r, bus.acc_x_r, bus.rsp_vld, bus.busy_r, bus.err_r} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b pass=%b clr=%b x=%0h rsp=%b busy=%b err=%b, want all 0",
               bus.req_rdy, bus.acc_pass_r, bus.acc_clear_r, bus.acc_x_r, bus.rsp_vld, bus.busy_r, bus.err_r);
    end
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({bus.req_rdy, bus.busy_r, bus.err_r, bus.rsp_vld} !== '0) begin
      n_err++;
      $display("FAIL idle_outputs: got rdy=%b busy=%b err=%b rsp=%b, want 0",
               bus.req_rdy, bus.busy_r, bus.err_r, bus.rsp_vld);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_sum();
    int unsigned r0;
    apply_reset();
    r0 = n_rsp;
    bq[0].push_back(mk(W'(3), 1'b0, 8'd0));
    bq[0].push_back(mk(W'(5), 1'b0, 8'd0));
    bq[0].push_back(mk(W'(7), 1'b1, 8'd0));
    run(60);
    n_cmp++;
    if (n_rsp - r0 !== 1) begin
      n_err++;
      $display("FAIL basic_rsp_count: got %0d, want 1", n_rsp - r0);
    end
  endtask

  task automatic test_round_robin();
    int unsigned c0;
    apply_reset();
    c0 = cyc;
    bq[1].push_back(mk(W'(10), 1'b0, 8'd0));
    bq[1].push_back(mk(W'(20), 1'b1, 8'd0));
    bq[2].push_back(mk(W'(1), 1'b0, 8'd0));
    bq[2].push_back(mk(W'(2), 1'b0, 8'd0));
    bq[2].push_back(mk(W'(3), 1'b1, 8'd0));
    run(100);
    n_cmp++;
    if (hs_first[1] !== c0 + 1) begin
      n_err++;
      $display("FAIL rr_first_grant: got req1 first beat cyc %0d, want %0d", hs_first[1], c0 + 1);
    end
    n_cmp++;
    if (hs_first[2] !== hs_last[1] + 2) begin
      n_err++;
      $display("FAIL rr_bubble: got req2 first beat cyc %0d, want %0d", hs_first[2], hs_last[1] + 2);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned r0;
    apply_reset();
    r0 = n_rsp;
    bq[3].push_back(mk('1, 1'b1, 8'd0));
    step();
    step();
    bq[0].push_back(mk(W'(1), 1'b1, 8'd0));
    bq[1].push_back(mk('1, 1'b0, 8'd0));
    bq[1].push_back(mk(W'(2), 1'b1, 8'd0));
    run(100);
    n_cmp++;
    if (n_rsp - r0 !== 3) begin
      n_err++;
      $display("FAIL b2b_rsp_count: got %0d, want 3", n_rsp - r0);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    bq[0].push_back(mk(W'(1), 1'b0, 8'd0));
    bq[0].push_back(mk(W'(2), 1'b0, 8'd1));
    bq[0].push_back(mk(W'(3), 1'b1, 8'd2));
    repeat (3) step();
    n_cmp++;
    if (bus.busy_r !== 1'b1) begin
      n_err++;
      $display("FAIL gap_busy: got %b, want 1", bus.busy_r);
    end
    run(60);
    n_cmp++;
    if (hs_last[0] - hs_first[0] !== 5) begin
      n_err++;
      $display("FAIL gap_spacing: got %0d cycles first-to-last, want 5", hs_last[0] - hs_first[0]);
    end
  endtask

  task automatic test_err_and_reset();
    int unsigned r0;
    apply_reset();
    force_yvld = 1'b1;
    step();
    force_yvld = 1'b0;
    step();
    n_cmp++;
    if (bus.err_r !== 1'b1) begin
      n_err++;
      $display("FAIL err_set: got %b, want 1", bus.err_r);
    end
    repeat (5) step();
    n_cmp++;
    if (bus.err_r !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: got %b, want 1", bus.err_r);
    end
    apply_reset();
    r0 = n_rsp;
    bq[0].push_back(mk(W'(5), 1'b0, 8'd0));
    bq[0].push_back(mk(W'(6), 1'b0, 8'd0));
    bq[0].push_back(mk(W'(7), 1'b1, 8'd0));
    repeat (3) step();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({bus.req_rdy, bus.acc_pass_r, bus.acc_clear_r, bus.acc_x_r, bus.rsp_vld, bus.busy_r, bus.err_r} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got rdy=%b pass=%b clr=%b x=%0h rsp=%b busy=%b err=%b, want all 0",
               bus.req_rdy, bus.acc_pass_r, bus.acc_clear_r, bus.acc_x_r, bus.rsp_vld, bus.busy_r, bus.err_r);
    end
    apply_reset();
    repeat (12) step();
    n_cmp++;
    if ({bus.err_r, bus.busy_r} !== 2'b00 || n_rsp !== r0) begin
      n_err++;
      $display("FAIL midreset_flush: got err=%b busy=%b rsp=%0d, want 0 0 0", bus.err_r, bus.busy_r, n_rsp - r0);
    end
  endtask

  task automatic test_partial();
    int unsigned r0, want;
    apply_reset();
    r0   = n_rsp;
    want = PARTIAL ? 3 : 1;
    bq[2].push_back(mk(W'(1), 1'b0, 8'd0));
    bq[2].push_back(mk(W'(2), 1'b0, 8'd0));
    bq[2].push_back(mk(W'(3), 1'b1, 8'd0));
    run(60);
    n_cmp++;
    if (n_rsp - r0 !== want) begin
      n_err++;
      $display("FAIL partial_rsp_count: got %0d, want %0d", n_rsp - r0, want);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_round_robin();
    test_back_to_back();
    test_gaps();
    test_err_and_reset();
    test_partial();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
